piso_shift_tx: RTL and testbench
================================

// Module: piso_shift_tx
// PURPOSE
//  - Parallel-in/serial-out transmitter; counterpart of the 8-bit SIPO shift register.
//  - Captures a WIDTH-bit word on a LOAD/READY handshake and shifts it out on SER, MSB first.
//  - Each bit is held for TICK_DIV clocks.
//  - BIT_STB marks the last cycle of each bit, so a SIPO receiver clock-enabled by BIT_STB
//    rebuilds the word exactly.
//  - Sits between user logic (switches/registers) and the serial line on the FPGA top.
// PARAMETERS
//  - WIDTH     8  data bits per frame (>=2)
//  - TICK_DIV  4  clocks per serial bit (>=1; 1 = one bit per clock)
// PORTS
//  - CLK      in   1      system clock, rising edge
//  - RST      in   1      asynchronous, active-high reset
//  - LOAD     in   1      request to transmit DIN; honoured only while READY=1
//  - DIN      in   WIDTH  parallel word, sampled on the accepting edge
//  - READY    out  1      idle, a LOAD will be accepted
//  - SER      out  1      serial data, MSB first
//  - BIT_STB  out  1      1-cycle pulse in the last cycle of every bit period
//  - DONE     out  1      1-cycle pulse when a frame completes
// BEHAVIOUR
//  - Reset values: READY=1, SER=0, BIT_STB=0, DONE=0; state IDLE; shift reg, bit_cnt, tick_cnt = 0.
//  - Reset is asynchronous and takes effect immediately, including mid-frame.
//    The frame in progress is abandoned, never resumed.
//  - FSM states: IDLE, SHIFT.
//  - IDLE -> SHIFT on an edge where LOAD=1 and READY=1:
//    - shreg<=DIN, SER<=DIN[WIDTH-1], bit_cnt<=0, tick_cnt<=0, READY<=0.
//  - SHIFT, tick_cnt < TICK_DIV-1: tick_cnt++; SER held.
//  - BIT_STB is combinational: (state==SHIFT && tick_cnt==TICK_DIV-1).
//  - SHIFT, tick_cnt==TICK_DIV-1, not last bit: tick_cnt<=0, bit_cnt++, shreg<<=1, SER<=next bit.
//  - SHIFT, tick_cnt==TICK_DIV-1, last bit: -> IDLE, SER<=0, READY<=1, DONE<=1 for one cycle.
//  - Latency: accepted at edge k -> MSB on SER from edge k.
//    DONE and READY rise at edge k + NBITS*TICK_DIV. NBITS = WIDTH (WIDTH+1 with parity).
//  - LOAD while READY=0 is ignored; no queuing. DIN changes after acceptance do not affect the frame.
//  - LOAD held high continuously: the next frame is accepted on the edge after DONE.
//    Minimum inter-frame gap is 1 idle cycle with SER=0.
//  - Counter widths: tick_cnt = clog2(TICK_DIV) (min 1), bit_cnt = clog2(WIDTH+1).
//    Counters never exceed their terminal values.
//  - TICK_DIV=1: BIT_STB is high on every SHIFT cycle.
// CONFIGURATION
//  - PISO_TX_PARITY_EN defined:
//    - An extra bit is appended after the LSB: even parity = ^DIN of the captured word.
//    - NBITS = WIDTH+1; BIT_STB also pulses for the parity bit.
//  - PISO_TX_PARITY_EN undefined: NBITS = WIDTH; no parity logic is synthesised.
// STRUCTURE
//  - Package piso_tx_pkg:
//    - state encoding ST_IDLE=1'b0, ST_SHIFT=1'b1.
//    - clog2 function for the counter widths.
//  - Sub-module bit_tick_gen (TICK_DIV):
//    - counter with clear/enable; outputs the tick at terminal count (drives BIT_STB).
//    - cleared on frame accept and on reset.
//  - Top holds the FSM, the shift register, the parity bit and the output registers.
// TESTING (WIDTH=8, TICK_DIV=4)
//  - Reset then idle:
//    - RST=1 for 3 cycles mid-stream -> READY=1, SER=0, BIT_STB=0, DONE=0, asynchronously.
//  - Single frame:
//    - LOAD 1 cycle, DIN=8'hA5 -> SER=1,0,1,0,0,1,0,1, each for 4 clocks.
//    - DONE pulse 32 clocks after accept; 8 BIT_STB pulses.
//  - Loopback: a SIPO receiver clocked by CLK with enable=BIT_STB, fed by SER
//    -> captures 8'h3C after DONE for DIN=8'h3C.
//  - Busy LOAD: DIN=8'hFF accepted; LOAD with DIN=8'h00 at cycle 10
//    -> ignored, SER stays all-ones, exactly one DONE.
//  - Back-to-back: LOAD held high with DIN=8'h81 then 8'h7E
//    -> frames separated by exactly one SER=0 idle cycle; DONE period = 33 clocks.
//  - Parity (PISO_TX_PARITY_EN): DIN=8'h07 -> 9th bit = 1; DONE at 36 clocks.
//    Mid-frame reset at bit 5 -> aborted, READY=1.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared constants for the PISO serial transmitter: FSM encoding and counter sizing.
package piso_tx_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts TICK_DIV enabled clocks and flags the last one of each period.
module bit_tick_gen
  import piso_tx_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = clog2(TICK_DIV);
  localparam logic [TW-1:0] TERM = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;

  assign tick = en && (tick_cnt == TERM);

  // Wraps to zero on the terminal count so it never passes TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tick_cnt <= '0;
    else if (clr)
      tick_cnt <= '0;
    else if (en)
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter, MSB first, each bit held TICK_DIV clocks.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the LSB.
module piso_shift_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             READY,
  output logic             SER,
  output logic             BIT_STB,
  output logic             DONE
);

`ifdef PISO_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW = clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             accept;
  logic             shifting;
  logic             tick;
  logic             next_bit;

  assign accept   = LOAD && READY;
  assign shifting = (state == ST_SHIFT);
  assign BIT_STB  = tick;

  bit_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (CLK),
    .rst  (RST),
    .clr  (accept),
    .en   (shifting),
    .tick (tick)
  );

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      par_q <= 1'b0;
    else if (accept)
      par_q <= ^DIN;
  end

  // After the LSB the parity bit goes out instead of stale shift data.
  assign next_bit = (bit_cnt == BW'(WIDTH - 1)) ? par_q : shreg[WIDTH-2];
`else
  assign next_bit = shreg[WIDTH-2];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      SER     <= 1'b0;
      READY   <= 1'b1;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          state   <= ST_SHIFT;
          shreg   <= DIN;
          SER     <= DIN[WIDTH-1];
          bit_cnt <= '0;
          READY   <= 1'b0;
        end
      end else if (tick) begin
        if (bit_cnt == LAST_BIT) begin
          state <= ST_IDLE;
          SER   <= 1'b0;
          READY <= 1'b1;
          DONE  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg   <= shreg << 1;
          SER     <= next_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (WIDTH=8, TICK_DIV=4); parity checks follow PISO_TX_PARITY_EN.
module tb_piso_shift_tx;

  localparam int W  = 8;
  localparam int TD = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int FRAME = NB * TD;

  logic         CLK = 1'b0;
  logic         RST;
  logic         LOAD;
  logic [W-1:0] DIN;
  logic         READY, SER, BIT_STB, DONE;
  logic [NB-1:0] rx;

  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_tx #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .LOAD    (LOAD),
    .DIN     (DIN),
    .READY   (READY),
    .SER     (SER),
    .BIT_STB (BIT_STB),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  // Loopback SIPO receiver
  always_ff @(posedge CLK) begin
    if (BIT_STB) rx <= {rx[NB-2:0], SER};
  end

  function automatic logic exp_bit(input logic [W-1:0] d, input int b);
    if (b < W) return d[W-1-b];
    return ^d;
  endfunction

  function automatic logic [NB-1:0] exp_rx(input logic [W-1:0] d);
`ifdef PISO_TX_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic test_reset();
    n_checks++;
    if ({READY, SER, BIT_STB, DONE} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_state: got RDY/SER/STB/DONE=%b want 1000", {READY, SER, BIT_STB, DONE});
    end
    @(negedge CLK); RST = 1'b0; LOAD = 1'b1; DIN = 8'hFF;
    @(negedge CLK); LOAD = 1'b0;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (READY !== 1'b0 || SER !== 1'b1) begin
      n_fail++; $display("FAIL reset_prestart: got READY=%b SER=%b want 0 1", READY, SER);
    end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({READY, SER, BIT_STB, DONE} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_async: got RDY/SER/STB/DONE=%b want 1000", {READY, SER, BIT_STB, DONE});
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (FRAME + 4) @(negedge CLK);
    n_checks++;
    if ({READY, SER, BIT_STB, DONE} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_abandon: got RDY/SER/STB/DONE=%b want 1000", {READY, SER, BIT_STB, DONE});
    end
  endtask

  task automatic test_single_frame(input logic [W-1:0] d);
    int bad, stb;
    bad = 0; stb = 0;
    @(negedge CLK); LOAD = 1'b1; DIN = d;
    @(negedge CLK); LOAD = 1'b0; DIN = ~d;
    for (int i = 0; i < FRAME; i++) begin
      if (SER !== exp_bit(d, i / TD) || DONE !== 1'b0 || READY !== 1'b0 ||
          BIT_STB !== ((i % TD) == TD - 1)) bad++;
      if (BIT_STB === 1'b1) stb++;
      @(negedge CLK);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL single_serial: %0d bad cycles for DIN=%h, want 0", bad, d);
    end
    n_checks++;
    if (stb != NB) begin
      n_fail++; $display("FAIL single_stb_count: got %0d strobes want %0d", stb, NB);
    end
    n_checks++;
    if ({DONE, READY, SER, BIT_STB} !== 4'b1100) begin
      n_fail++; $display("FAIL single_done: got DONE/RDY/SER/STB=%b want 1100", {DONE, READY, SER, BIT_STB});
    end
    @(negedge CLK);
    n_checks++;
    if (DONE !== 1'b0) begin
      n_fail++; $display("FAIL single_done_width: got DONE=%b want 0", DONE);
    end
  endtask

  task automatic test_loopback(input logic [W-1:0] d);
    int t;
    t = -1;
    @(negedge CLK); LOAD = 1'b1; DIN = d;
    @(negedge CLK); LOAD = 1'b0;
    for (int c = 0; c < 2 * FRAME && t < 0; c++) begin
      if (DONE === 1'b1) t = c;
      else @(negedge CLK);
    end
    n_checks++;
    if (t != FRAME) begin
      n_fail++; $display("FAIL loopback_latency: DONE at %0d want %0d", t, FRAME);
    end
    n_checks++;
    if (rx !== exp_rx(d)) begin
      n_fail++; $display("FAIL loopback_data: got %h want %h", rx, exp_rx(d));
    end
  endtask

  task automatic test_busy_load();
    int bad, dones;
    bad = 0; dones = 0;
    @(negedge CLK); LOAD = 1'b1; DIN = 8'hFF;
    @(negedge CLK); LOAD = 1'b0;
    for (int i = 0; i < FRAME + 6; i++) begin
      if (i < FRAME && SER !== exp_bit(8'hFF, i / TD)) bad++;
      if (i >= FRAME && SER !== 1'b0) bad++;
      if (DONE === 1'b1) dones++;
      if (i == 9) begin LOAD = 1'b1; DIN = 8'h00; end
      if (i == 10) LOAD = 1'b0;
      @(negedge CLK);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL busy_serial: %0d bad cycles, want 0", bad);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL busy_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1; d2 = -1;
    @(negedge CLK); LOAD = 1'b1; DIN = 8'h81;
    @(negedge CLK); DIN = 8'h7E;
    for (int c = 0; c < 3 * FRAME && d2 < 0; c++) begin
      if (DONE === 1'b1) begin
        if (d1 < 0) begin
          d1 = c;
          n_checks++;
          if (SER !== 1'b0 || READY !== 1'b1 || rx !== exp_rx(8'h81)) begin
            n_fail++; $display("FAIL b2b_first: SER=%b READY=%b rx=%h want 0 1 %h", SER, READY, rx, exp_rx(8'h81));
          end
        end else begin
          d2 = c;
          n_checks++;
          if (rx !== exp_rx(8'h7E)) begin
            n_fail++; $display("FAIL b2b_second: rx=%h want %h", rx, exp_rx(8'h7E));
          end
        end
      end else if (d1 >= 0 && c == d1 + 1) begin
        n_checks++;
        if (READY !== 1'b0) begin
          n_fail++; $display("FAIL b2b_reaccept: READY=%b want 0", READY);
        end
        LOAD = 1'b0;
      end
      if (d2 < 0) @(negedge CLK);
    end
    LOAD = 1'b0;
    n_checks++;
    if (d1 != FRAME) begin
      n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", d1, FRAME);
    end
    n_checks++;
    if (d2 < 0 || d2 - d1 != FRAME + 1) begin
      n_fail++; $display("FAIL b2b_period: got %0d want %0d", (d2 < 0) ? -1 : d2 - d1, FRAME + 1);
    end
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    int t, bad;
    t = -1; bad = 0;
    @(negedge CLK); LOAD = 1'b1; DIN = 8'h07;
    @(negedge CLK); LOAD = 1'b0;
    for (int c = 0; c < 2 * FRAME && t < 0; c++) begin
      if (c >= W * TD && c < FRAME && SER !== 1'b1) bad++;
      if (DONE === 1'b1) t = c;
      else @(negedge CLK);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL parity_bit: %0d cycles with parity bit != 1", bad);
    end
    n_checks++;
    if (t != 36) begin
      n_fail++; $display("FAIL parity_latency: DONE at %0d want 36", t);
    end
    @(negedge CLK); LOAD = 1'b1; DIN = 8'h07;
    @(negedge CLK); LOAD = 1'b0;
    repeat (5 * TD + 1) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (READY !== 1'b1 || SER !== 1'b0) begin
      n_fail++; $display("FAIL parity_abort: READY=%b SER=%b want 1 0", READY, SER);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    bad = 0;
    for (int c = 0; c < FRAME + 4; c++) begin
      if (DONE !== 1'b0 || READY !== 1'b1) bad++;
      @(negedge CLK);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL parity_abort_idle: %0d non-idle cycles after abort", bad);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; LOAD = 1'b0; DIN = '0;
    #1;
    test_reset();
    test_single_frame(8'hA5);
    test_loopback(8'h3C);
    test_busy_load();
    test_back_to_back();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
